store_data_fwd_unit: RTL and testbench
======================================

Name: store_data_fwd_unit

Overview:
- Registered store-data forwarding and byte-lane alignment stage at the EX/MEM boundary of the RISC-V pipeline.
- Resolves the store source operand (rs2) against the current writeback result and a DEPTH-entry history of recent writebacks, falling back to the register-file value.
- Aligns the resolved data to the target byte lanes for SB/SH/SW(/SD) and produces byte enables and a misalignment flag for the data memory.

Parameters:
DATA_WIDTH, 32, store data width in bits; legal values are 32 or 64.
REG_ADDR_WIDTH, 5, register index width.
DEPTH, 4, number of retired-writeback history entries; legal range is 1..8.

Ports:
clk  in  1  pipeline clock, all state on rising edge
reset  in  1  synchronous, active-high reset
stall_i  in  1  hold output registers and ignore the store request this cycle
flush_i  in  1  kill the store request this cycle (output valid forced to 0)
wb_en_i  in  1  writeback valid this cycle
wb_rd_i  in  REG_ADDR_WIDTH  writeback destination register
wb_data_i  in  DATA_WIDTH  writeback value
st_valid_i  in  1  store request present
st_rs2_i  in  REG_ADDR_WIDTH  store source register
st_rs2_data_i  in  DATA_WIDTH  rs2 value read from the register file
st_size_i  in  2  00=byte, 01=half, 10=word, 11=double (double is legal only when DATA_WIDTH=64)
st_addr_lo_i  in  log2(DATA_WIDTH/8)  low address bits
st_valid_o  out  1  registered store valid
st_data_o  out  DATA_WIDTH  lane-aligned store data
st_be_o  out  DATA_WIDTH/8  byte enables
misalign_o  out  1  misaligned or illegal-size store; st_be_o=0
fwd_hit_o  out  1  data came from a forwarding source, not the register file
fwd_src_o  out  4  0=register file, 1=current writeback, 2+k=history entry k (k=0 is youngest)

Behaviour:
- Reset (synchronous, active-high): all history entries invalid; all outputs 0.
- History register (updated every cycle, including while stall_i or flush_i is asserted):
  - wb_en_i=1 and wb_rd_i!=0: shift in {valid=1, rd, data} at entry 0; older entries move down one place; entry DEPTH-1 is dropped.
  - wb_en_i=0 or wb_rd_i=0: no shift; history is held unchanged.
- Source resolution, combinational on the current inputs, priority high to low:
  1. st_rs2_i=0: data=0, fwd_src=0, hit=0.
  2. wb_en_i=1 and wb_rd_i==st_rs2_i: data=wb_data_i, fwd_src=1.
  3. Lowest k with entry k valid and entry k rd==st_rs2_i: data=entry k data, fwd_src=2+k.
  4. Otherwise: data=st_rs2_data_i, fwd_src=0.
  - Only the youngest matching entry is used. Duplicate rd values may exist in the history.
- Alignment, with lanes = DATA_WIDTH/8 and off = st_addr_lo_i:
  - Byte: data[7:0] replicated to every byte lane; be = 1 << off.
  - Half: low 16 bits replicated to every halfword; be = 2'b11 << off; misaligned if off[0]!=0.
  - Word: low 32 bits replicated; be = 4'hF << off; misaligned if off[1:0]!=0.
  - Double (64-bit only): be = all ones; misaligned if off!=0.
  - size=11 when DATA_WIDTH=32: illegal, so misalign_o=1.
  - When misaligned: be=0 and st_valid_o still follows the valid rules below.
- Output register, latency 1 cycle:
  - stall_i=1: all outputs hold their values (stall has priority over flush).
  - Else flush_i=1: st_valid_o=0, be=0, misalign_o=0, hit=0, fwd_src=0; data holds.
  - Else: load the resolved and aligned values; st_valid_o=st_valid_i; be is forced to 0 when st_valid_i=0.
- Reset asserted during a stall: reset wins and everything clears.
- Simultaneous wb_rd_i==st_rs2_i and a history match: the current writeback wins.

Test Plan:
- Reset held 2 cycles, then wb writes x5=0xAAAA5555 -> all outputs 0 during reset; entry 0 = {x5, 0xAAAA5555} after release.
- Same cycle: wb x7=0x11223344 and store SW rs2=x7, rf data=0xDEADBEEF, off=0 -> next cycle st_data_o=0x11223344, be=4'hF, fwd_src=1, hit=1.
- History x3=0x10, then x3=0x20, then 2 idle cycles; then SB rs2=x3, off=2 -> st_data_o=0x20202020, be=4'b0100, fwd_src=2.
- Fill history with DEPTH+1 distinct registers; store uses the first (evicted) register -> fwd_src=0 and data = st_rs2_data_i.
- SH with off=1 -> misalign_o=1, be=0, st_valid_o=1. Store with rs2=x0 while wb writes x0=0xFFFF -> st_data_o=0, hit=0.
- Store issued with stall_i=1 for 3 cycles, then flush_i=1 -> outputs frozen during the stall, then st_valid_o=0. A writeback made during the stall is still visible to the next store.

Source files
------------

// File: rtl/store_data_fwd_unit.sv
// Store-data forwarding and byte-lane alignment at the EX/MEM boundary.
// Resolves rs2 against the live writeback and a shift-register history of recent writebacks.
module store_data_fwd_unit #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int DEPTH          = 4,
  localparam int LANES         = DATA_WIDTH / 8,
  localparam int OFF_W         = $clog2(LANES)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      stall_i,
  input  logic                      flush_i,
  input  logic                      wb_en_i,
  input  logic [REG_ADDR_WIDTH-1:0] wb_rd_i,
  input  logic [DATA_WIDTH-1:0]     wb_data_i,
  input  logic                      st_valid_i,
  input  logic [REG_ADDR_WIDTH-1:0] st_rs2_i,
  input  logic [DATA_WIDTH-1:0]     st_rs2_data_i,
  input  logic [1:0]                st_size_i,
  input  logic [OFF_W-1:0]          st_addr_lo_i,
  output logic                      st_valid_o,
  output logic [DATA_WIDTH-1:0]     st_data_o,
  output logic [LANES-1:0]          st_be_o,
  output logic                      misalign_o,
  output logic                      fwd_hit_o,
  output logic [3:0]                fwd_src_o
);

  logic [DEPTH-1:0]          hist_valid_q, hist_valid_d;
  logic [REG_ADDR_WIDTH-1:0] hist_rd_q   [DEPTH];
  logic [REG_ADDR_WIDTH-1:0] hist_rd_d   [DEPTH];
  logic [DATA_WIDTH-1:0]     hist_data_q [DEPTH];
  logic [DATA_WIDTH-1:0]     hist_data_d [DEPTH];

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [LANES-1:0]      be_q, be_d;
  logic                  mis_q, mis_d;
  logic                  hit_q, hit_d;
  logic [3:0]            src_q, src_d;

  logic [DATA_WIDTH-1:0] src_data;
  logic [3:0]            src_sel;
  logic                  src_hit;
  logic [DATA_WIDTH-1:0] al_data;
  logic [LANES-1:0]      al_be;
  logic                  al_mis;

  // Writes to x0 never enter the history, so it cannot shadow the hardwired zero.
  always_comb begin
    hist_valid_d = hist_valid_q;
    hist_rd_d    = hist_rd_q;
    hist_data_d  = hist_data_q;
    if (wb_en_i && (wb_rd_i != '0)) begin
      for (int k = DEPTH - 1; k >= 1; k--) begin
        hist_valid_d[k] = hist_valid_q[k-1];
        hist_rd_d[k]    = hist_rd_q[k-1];
        hist_data_d[k]  = hist_data_q[k-1];
      end
      hist_valid_d[0] = 1'b1;
      hist_rd_d[0]    = wb_rd_i;
      hist_data_d[0]  = wb_data_i;
    end
  end

  // Scanning oldest to youngest lets the youngest duplicate overwrite older matches.
  always_comb begin
    src_data = st_rs2_data_i;
    src_sel  = 4'd0;
    src_hit  = 1'b0;
    if (st_rs2_i == '0) begin
      src_data = '0;
    end else if (wb_en_i && (wb_rd_i == st_rs2_i)) begin
      src_data = wb_data_i;
      src_sel  = 4'd1;
      src_hit  = 1'b1;
    end else begin
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (hist_valid_q[k] && (hist_rd_q[k] == st_rs2_i)) begin
          src_data = hist_data_q[k];
          src_sel  = 4'(k + 2);
          src_hit  = 1'b1;
        end
      end
    end
  end

  always_comb begin
    al_data = src_data;
    al_be   = '0;
    al_mis  = 1'b0;
    case (st_size_i)
      2'b00: begin
        al_data = {LANES{src_data[7:0]}};
        al_be   = LANES'(1) << st_addr_lo_i;
      end
      2'b01: begin
        al_data = {(LANES/2){src_data[15:0]}};
        al_be   = LANES'(2'b11) << st_addr_lo_i;
        al_mis  = st_addr_lo_i[0];
      end
      2'b10: begin
        al_data = {(LANES/4){src_data[31:0]}};
        al_be   = LANES'(4'hF) << st_addr_lo_i;
        al_mis  = (st_addr_lo_i[1:0] != 2'b00);
      end
      default: begin
        if (DATA_WIDTH == 64) begin
          al_be  = '1;
          al_mis = (st_addr_lo_i != '0);
        end else begin
          al_mis = 1'b1;
        end
      end
    endcase
    if (al_mis) al_be = '0;
  end

  // Stall freezes everything; flush clears the control outputs but leaves data alone.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    be_d    = be_q;
    mis_d   = mis_q;
    hit_d   = hit_q;
    src_d   = src_q;
    if (!stall_i) begin
      if (flush_i) begin
        valid_d = 1'b0;
        be_d    = '0;
        mis_d   = 1'b0;
        hit_d   = 1'b0;
        src_d   = 4'd0;
      end else begin
        valid_d = st_valid_i;
        data_d  = al_data;
        be_d    = st_valid_i ? al_be : '0;
        mis_d   = al_mis;
        hit_d   = src_hit;
        src_d   = src_sel;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hist_valid_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        hist_rd_q[k]   <= '0;
        hist_data_q[k] <= '0;
      end
      valid_q <= 1'b0;
      data_q  <= '0;
      be_q    <= '0;
      mis_q   <= 1'b0;
      hit_q   <= 1'b0;
      src_q   <= 4'd0;
    end else begin
      hist_valid_q <= hist_valid_d;
      hist_rd_q    <= hist_rd_d;
      hist_data_q  <= hist_data_d;
      valid_q      <= valid_d;
      data_q       <= data_d;
      be_q         <= be_d;
      mis_q        <= mis_d;
      hit_q        <= hit_d;
      src_q        <= src_d;
    end
  end

  assign st_valid_o = valid_q;
  assign st_data_o  = data_q;
  assign st_be_o    = be_q;
  assign misalign_o = mis_q;
  assign fwd_hit_o  = hit_q;
  assign fwd_src_o  = src_q;

endmodule

// File: tb/tb_store_data_fwd_unit.sv
// Scoreboard bench for store_data_fwd_unit (32-bit data, 4-entry history).
// Stimulus pushes hand-computed expectations tagged with the cycle they apply to.
module tb_store_data_fwd_unit;

  logic        clk = 1'b0;
  logic        reset, stall_i, flush_i, wb_en_i, st_valid_i;
  logic [4:0]  wb_rd_i, st_rs2_i;
  logic [31:0] wb_data_i, st_rs2_data_i;
  logic [1:0]  st_size_i, st_addr_lo_i;
  logic        st_valid_o, misalign_o, fwd_hit_o;
  logic [31:0] st_data_o;
  logic [3:0]  st_be_o, fwd_src_o;

  typedef struct {
    int          cyc;
    string       nm;
    logic        v;
    logic [31:0] d;
    bit          dCare;
    logic [3:0]  be;
    logic        mis;
    logic        hit;
    logic [3:0]  src;
  } exp_t;

  exp_t expQ[$];
  int   cycCount = 0;
  int   errors = 0;
  int   checks = 0;

  store_data_fwd_unit #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .stall_i(stall_i), .flush_i(flush_i),
    .wb_en_i(wb_en_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i),
    .st_valid_i(st_valid_i), .st_rs2_i(st_rs2_i), .st_rs2_data_i(st_rs2_data_i),
    .st_size_i(st_size_i), .st_addr_lo_i(st_addr_lo_i),
    .st_valid_o(st_valid_o), .st_data_o(st_data_o), .st_be_o(st_be_o),
    .misalign_o(misalign_o), .fwd_hit_o(fwd_hit_o), .fwd_src_o(fwd_src_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycCount <= cycCount + 1;

  // Monitor: compares every expectation registered for the cycle just completed.
  always @(negedge clk) begin
    while (expQ.size() > 0 && expQ[0].cyc <= cycCount) begin
      exp_t e;
      e = expQ.pop_front();
      checkOutput(e);
    end
  end

  task automatic checkOutput(input exp_t e);
    bit ok;
    ok = (e.cyc == cycCount) && (st_valid_o === e.v) && (st_be_o === e.be) &&
         (misalign_o === e.mis) && (fwd_hit_o === e.hit) && (fwd_src_o === e.src) &&
         (!e.dCare || (st_data_o === e.d));
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL %s: got v=%b d=%h be=%b mis=%b hit=%b src=%0d, expected v=%b d=%h be=%b mis=%b hit=%b src=%0d",
               e.nm, st_valid_o, st_data_o, st_be_o, misalign_o, fwd_hit_o, fwd_src_o,
               e.v, e.d, e.be, e.mis, e.hit, e.src);
    end
  endtask

  task automatic drv(input logic rst, input logic stl, input logic fl,
                     input logic wen, input logic [4:0] wrd, input logic [31:0] wdat,
                     input logic sv, input logic [4:0] rs2, input logic [31:0] rf,
                     input logic [1:0] sz, input logic [1:0] off);
    reset = rst; stall_i = stl; flush_i = fl;
    wb_en_i = wen; wb_rd_i = wrd; wb_data_i = wdat;
    st_valid_i = sv; st_rs2_i = rs2; st_rs2_data_i = rf;
    st_size_i = sz; st_addr_lo_i = off;
  endtask

  task automatic applyStimulus(input bit chk, input string nm, input logic v,
                               input logic [31:0] d, input bit dCare, input logic [3:0] be,
                               input logic mis, input logic hit, input logic [3:0] src);
    if (chk) expQ.push_back('{cycCount + 1, nm, v, d, dCare, be, mis, hit, src});
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycle();
    drv(0, 0, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 2'b00, 2'd0);
    applyStimulus(0, "", 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] store_data_fwd_unit bench start");
    drv(1, 0, 0, 0, 5'd0, 32'h0, 1, 5'd1, 32'h12345678, 2'b10, 2'd0);
    applyStimulus(1, "reset_c1", 0, 32'h0, 1, 4'h0, 0, 0, 0);
    applyStimulus(1, "reset_c2", 0, 32'h0, 1, 4'h0, 0, 0, 0);

    drv(0, 0, 0, 1, 5'd5, 32'hAAAA5555, 0, 5'd0, 32'h0, 2'b00, 2'd0);
    applyStimulus(1, "wb_x5_idle_out", 0, 32'h0, 1, 4'h0, 0, 0, 0);
    drv(0, 0, 0, 0, 5'd0, 32'h0, 1, 5'd5, 32'h0, 2'b10, 2'd0);
    applyStimulus(1, "hist_entry0_x5", 1, 32'hAAAA5555, 1, 4'hF, 0, 1, 2);

    drv(0, 0, 0, 1, 5'd7, 32'h11223344, 1, 5'd7, 32'hDEADBEEF, 2'b10, 2'd0);
    applyStimulus(1, "fwd_current_wb", 1, 32'h11223344, 1, 4'hF, 0, 1, 1);

    drv(0, 0, 0, 1, 5'd3, 32'h10, 0, 5'd0, 32'h0, 2'b00, 2'd0);
    applyStimulus(1, "no_store_out", 0, 32'h0, 1, 4'h0, 0, 0, 0);
    drv(0, 0, 0, 1, 5'd3, 32'h20, 0, 5'd0, 32'h0, 2'b00, 2'd0);
    applyStimulus(0, "", 0, 0, 0, 0, 0, 0, 0);
    idleCycle();
    idleCycle();
    drv(0, 0, 0, 0, 5'd0, 32'h0, 1, 5'd3, 32'h0, 2'b00, 2'd2);
    applyStimulus(1, "sb_youngest_dup", 1, 32'h20202020, 1, 4'b0100, 0, 1, 2);

    for (int i = 0; i < 5; i++) begin
      drv(0, 0, 0, 1, 5'(10 + i), 32'hA0 + 32'(i), 0, 5'd0, 32'h0, 2'b00, 2'd0);
      applyStimulus(0, "", 0, 0, 0, 0, 0, 0, 0);
    end
    drv(0, 0, 0, 0, 5'd0, 32'h0, 1, 5'd10, 32'hCAFEF00D, 2'b10, 2'd0);
    applyStimulus(1, "evicted_uses_rf", 1, 32'hCAFEF00D, 1, 4'hF, 0, 0, 0);
    drv(0, 0, 0, 0, 5'd0, 32'h0, 1, 5'd11, 32'h0, 2'b10, 2'd0);
    applyStimulus(1, "oldest_entry3", 1, 32'h000000A1, 1, 4'hF, 0, 1, 5);
    drv(0, 0, 0, 0, 5'd0, 32'h0, 1, 5'd12, 32'h0, 2'b01, 2'd2);
    applyStimulus(1, "sh_off2_entry2", 1, 32'h00A200A2, 1, 4'b1100, 0, 1, 4);
    drv(0, 0, 0, 0, 5'd0, 32'h0, 1, 5'd13, 32'h0, 2'b01, 2'd1);
    applyStimulus(1, "sh_misaligned", 1, 32'h00A300A3, 1, 4'h0, 1, 1, 3);
    drv(0, 0, 0, 1, 5'd0, 32'hFFFF, 1, 5'd0, 32'h55, 2'b10, 2'd0);
    applyStimulus(1, "rs2_x0_zero", 1, 32'h0, 1, 4'hF, 0, 0, 0);
    drv(0, 0, 0, 0, 5'd0, 32'h0, 1, 5'd14, 32'h0, 2'b10, 2'd0);
    applyStimulus(1, "x0_wb_not_hist", 1, 32'h000000A4, 1, 4'hF, 0, 1, 2);
    drv(0, 0, 0, 0, 5'd0, 32'h0, 1, 5'd14, 32'h0, 2'b11, 2'd0);
    applyStimulus(1, "sd_illegal_32", 1, 32'h0, 0, 4'h0, 1, 1, 2);

    drv(0, 0, 0, 0, 5'd0, 32'h0, 1, 5'd20, 32'h01020304, 2'b10, 2'd0);
    applyStimulus(1, "pre_stall_load", 1, 32'h01020304, 1, 4'hF, 0, 0, 0);
    drv(0, 1, 0, 1, 5'd20, 32'h77, 1, 5'd14, 32'h0, 2'b00, 2'd1);
    applyStimulus(1, "stall_hold_1", 1, 32'h01020304, 1, 4'hF, 0, 0, 0);
    drv(0, 1, 0, 0, 5'd0, 32'h0, 1, 5'd14, 32'h0, 2'b00, 2'd1);
    applyStimulus(1, "stall_hold_2", 1, 32'h01020304, 1, 4'hF, 0, 0, 0);
    applyStimulus(1, "stall_hold_3", 1, 32'h01020304, 1, 4'hF, 0, 0, 0);
    drv(0, 0, 1, 0, 5'd0, 32'h0, 1, 5'd14, 32'h0, 2'b00, 2'd1);
    applyStimulus(1, "flush_clears", 0, 32'h01020304, 1, 4'h0, 0, 0, 0);
    drv(0, 0, 0, 0, 5'd0, 32'h0, 1, 5'd20, 32'h0, 2'b10, 2'd0);
    applyStimulus(1, "wb_during_stall", 1, 32'h00000077, 1, 4'hF, 0, 1, 2);
    drv(0, 0, 0, 1, 5'd20, 32'h99, 1, 5'd20, 32'h0, 2'b10, 2'd0);
    applyStimulus(1, "wb_beats_hist", 1, 32'h00000099, 1, 4'hF, 0, 1, 1);

    drv(1, 1, 0, 0, 5'd0, 32'h0, 1, 5'd20, 32'h0, 2'b10, 2'd0);
    applyStimulus(1, "reset_over_stall", 0, 32'h0, 1, 4'h0, 0, 0, 0);
    drv(0, 0, 0, 0, 5'd0, 32'h0, 1, 5'd20, 32'h5A5A5A5A, 2'b10, 2'd0);
    applyStimulus(1, "hist_cleared", 1, 32'h5A5A5A5A, 1, 4'hF, 0, 0, 0);
    drv(0, 0, 0, 0, 5'd0, 32'h0, 0, 5'd20, 32'h5A5A5A5A, 2'b10, 2'd0);
    applyStimulus(1, "invalid_be_zero", 0, 32'h5A5A5A5A, 1, 4'h0, 0, 0, 0);

    idleCycle();
    idleCycle();
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", expQ.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
